// File: rtl/fifo_rd_pkg.sv
// Shared constants and types for the FIFO read-side drain engine.
// Imported by the skid buffer and the drain top level.
package fifo_rd_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_CNT_WIDTH  = 16;

    // Buffer occupancy, 0..2
    typedef logic [1:0] occ_t;

    localparam occ_t OCC_FULL = 2'd2;

endpackage

// File: rtl/fifo_rd_skid.sv
// Two-entry circular buffer that absorbs the FIFO read latency.
// Head data is always taken from registered entries, never bypassed.
module fifo_rd_skid
    import fifo_rd_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output occ_t                  occ,
    output logic                  valid,
    output logic [DATA_WIDTH-1:0] head
);

    logic [DATA_WIDTH-1:0] mem [2];
    logic                  wr_ptr;
    logic                  rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    // A push into a full buffer without a pop would overwrite the head;
    // it is dropped here and flagged as overflow by the top level.
    assign do_push = push & ((occ != OCC_FULL) | pop);
    assign do_pop  = pop & (occ != 2'd0);

    assign valid = (occ != 2'd0);
    assign head  = mem[rd_ptr];

    // Storage, pointers and occupancy update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            occ    <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            occ <= occ + occ_t'(do_push) - occ_t'(do_pop);
        end
    end

endmodule

// File: rtl/fifo_rd_drain.sv
// Read-side drain engine: issues FIFO reads, buffers the returned words,
// streams them out on valid/ready, counts deliveries and latches errors.
module fifo_rd_drain
    import fifo_rd_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
    input  logic                  r_clk,
    input  logic                  rrst_n,
    input  logic                  enable,
    input  logic                  empty,
    input  logic [DATA_WIDTH-1:0] data_out,
    input  logic                  read_error,
    output logic                  r_en,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [CNT_WIDTH-1:0]  rd_count,
    output logic                  err_sticky,
    input  logic                  clr_err,
    output logic                  idle
);

    logic inflight;
    logic pop;
    occ_t occ;
    occ_t used;
    logic overflow;
    logic err_set;

    assign pop  = m_valid & m_ready;
    assign used = occ + occ_t'(inflight);

    // Issue a read only when its word is guaranteed a buffer slot.
    // Held low during reset so nothing is consumed from the FIFO.
    assign r_en = rrst_n & enable & ~empty &
                  ((used < OCC_FULL) | ((used == OCC_FULL) & pop));

    assign idle     = (occ == 2'd0) & ~inflight;
    assign overflow = inflight & (occ == OCC_FULL) & ~pop;
    assign err_set  = read_error | overflow;

    fifo_rd_skid #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_skid (
        .clk      (r_clk),
        .rst_n    (rrst_n),
        .push     (inflight),
        .push_data(data_out),
        .pop      (pop),
        .occ      (occ),
        .valid    (m_valid),
        .head     (m_data)
    );

    // Track the read whose data returns next cycle
    always_ff @(posedge r_clk or negedge rrst_n) begin
        if (!rrst_n) begin
            inflight <= 1'b0;
        end else begin
            inflight <= r_en;
        end
    end

    // Delivered-word counter, wraps silently
    always_ff @(posedge r_clk or negedge rrst_n) begin
        if (!rrst_n) begin
            rd_count <= '0;
        end else if (pop) begin
            rd_count <= rd_count + 1'b1;
        end
    end

    // Sticky error; clear wins over a same-cycle set
    always_ff @(posedge r_clk or negedge rrst_n) begin
        if (!rrst_n) begin
            err_sticky <= 1'b0;
        end else if (clr_err) begin
            err_sticky <= 1'b0;
        end else if (err_set) begin
            err_sticky <= 1'b1;
        end
    end

endmodule
